multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 101 ++++++++++
 tb/tb_multiport_register_file.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - 4-read/2-write register file with pending-producer scoreboard
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*ADDR_WIDTH-1:0]   ra,
  output logic [4*DATA_WIDTH-1:0]   rd,
  output logic [3:0]                rd_busy,
  input  logic [1:0]                we,
  input  logic [2*ADDR_WIDTH-1:0]   wa,
  input  logic [2*DATA_WIDTH-1:0]   wd,
  input  logic [1:0]                rsv_en,
  input  logic [2*ADDR_WIDTH-1:0]   rsv_addr,
  output logic [ADDR_WIDTH:0]       pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;

  // Port 1 is applied after port 0 so it wins an address conflict.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int j = 0; j < 2; j++) begin
      if (we[j] && (wa[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        regs_d[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = wd[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Clears first, then sets, so a reservation beats a completing write.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < 2; j++) begin
      if (we[j]) begin
        pend_d[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rsv_en[k]) begin
        pend_d[rsv_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d = cnt_d + (ADDR_WIDTH + 1)'(pend_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rst && (ra[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        rd[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra[i*ADDR_WIDTH +: ADDR_WIDTH]];
        rd_busy[i]                     = pend_q[ra[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < 2; j++) begin
          if (we[j] && (wa[j*ADDR_WIDTH +: ADDR_WIDTH] == ra[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd[i*DATA_WIDTH +: DATA_WIDTH] = wd[j*DATA_WIDTH +: DATA_WIDTH];
            rd_busy[i]                     = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - randomized and directed checks against an array reference model
module tb_multiport_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*AW-1:0] ra = '0;
  logic [4*DW-1:0] rd;
  logic [3:0]      rd_busy;
  logic [1:0]      we = '0;
  logic [2*AW-1:0] wa = '0;
  logic [2*DW-1:0] wd = '0;
  logic [1:0]      rsv_en = '0;
  logic [2*AW-1:0] rsv_addr = '0;
  logic [AW:0]     pend_cnt;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  multiport_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; rsv_en = '0; rsv_addr = '0;
  endtask

  task automatic set_ra(input int i, input int a);
    ra[i*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
    we[j] = 1'b1;
    wa[j*AW +: AW] = AW'(a);
    wd[j*DW +: DW] = d;
  endtask

  task automatic set_rsv(input int k, input int a);
    rsv_en[k] = 1'b1;
    rsv_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic check_reads(input string tag);
    for (int i = 0; i < 4; i++) begin
      int a;
      logic [DW-1:0] ed;
      logic eb;
      a  = int'(ra[i*AW +: AW]);
      ed = (a == 0) ? '0 : m_regs[a];
      eb = (a == 0) ? 1'b0 : m_pend[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < 2; j++) begin
        if (a != 0 && we[j] && int'(wa[j*AW +: AW]) == a) begin
          ed = wd[j*DW +: DW];
          eb = 1'b0;
        end
      end
`endif
      chk($sformatf("%s rd%0d", tag, i), 64'(rd[i*DW +: DW]), 64'(ed));
      chk($sformatf("%s busy%0d", tag, i), 64'(rd_busy[i]), 64'(eb));
    end
  endtask

  // Inputs are set just after a falling edge; reads checked, then the rising edge is taken.
  task automatic cycle(input string tag);
    #1;
    check_reads(tag);
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      int a = int'(wa[j*AW +: AW]);
      if (we[j] && a != 0) begin
        m_regs[a] = wd[j*DW +: DW];
        m_pend[a] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      int a = int'(rsv_addr[k*AW +: AW]);
      if (rsv_en[k] && a != 0) m_pend[a] = 1'b1;
    end
    #1;
    chk({tag, " pend_cnt"}, 64'(pend_cnt), 64'(model_count()));
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    we = 2'b11; rsv_en = 2'b11;
    wa = {AW'(12), AW'(13)}; rsv_addr = {AW'(14), AW'(15)};
    wd = {32'hAAAA5555, 32'h5555AAAA};
    #1;
    model_clear();
    chk({tag, " async pend_cnt"}, 64'(pend_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s async rd%0d", tag, i), 64'(rd[i*DW +: DW]), 64'd0);
      chk($sformatf("%s async busy%0d", tag, i), 64'(rd_busy[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, " held pend_cnt"}, 64'(pend_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  initial begin
    model_clear();
    ra = {AW'(5), AW'(7), AW'(9), AW'(31)};
    #1;
    chk("por pend_cnt", 64'(pend_cnt), 64'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("por rd%0d", i), 64'(rd[i*DW +: DW]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // r5 written and r6 reserved, then wiped by a reset pulse
    set_wr(0, 5, 32'hDEADBEEF); set_rsv(0, 6); set_ra(0, 5);
    cycle("wr5");
    idle(); set_ra(0, 5); set_ra(1, 6);
    cycle("rd5");
    set_ra(0, 5);
    pulse_reset("rst5");
    cycle("after_rst");

    set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
    cycle("dual7");
    idle(); set_ra(0, 7);
    cycle("rd7");

    set_rsv(1, 2);
    cycle("pre_r0");
    idle();
    set_wr(0, 0, 32'hFFFFFFFF); set_rsv(0, 0); ra = '0;
    cycle("r0");
    idle();
    cycle("r0_after");

    set_rsv(0, 3); set_rsv(1, 4);
    cycle("rsv34");
    idle(); set_ra(0, 3); set_ra(1, 4);
    chk("rsv34 cnt2", 64'(pend_cnt), 64'd3);
    set_wr(0, 3, 32'h33);
    cycle("wr3");
    idle(); set_wr(1, 4, 32'h44); set_rsv(0, 4); set_ra(2, 4);
    cycle("rsv_wr4");
    idle(); set_ra(0, 4);
    cycle("chk4");

    set_wr(0, 9, 32'h0BAD);
    cycle("pre9");
    idle(); set_ra(0, 9); set_wr(0, 9, 32'h1234);
    cycle("byp9");
    idle(); set_ra(0, 9);
    cycle("post9");

    // Clear everything, then reserve r1..r31 two per cycle
    pulse_reset("fill_pre");
    for (int r = 1; r < NR; r += 2) begin
      idle();
      set_rsv(0, r);
      set_rsv(1, (r + 1 < NR) ? r + 1 : r);
      cycle($sformatf("fill%0d", r));
    end
    chk("fill full", 64'(pend_cnt), 64'(NR - 1));
    for (int r = 1; r < 9; r += 2) begin
      idle(); set_rsv(0, r); set_rsv(1, r + 1);
      cycle($sformatf("refill%0d", r));
    end
    pulse_reset("fill_mid");

    for (int n = 0; n < 300; n++) begin
      idle();
      for (int i = 0; i < 4; i++) set_ra(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, NR - 1)));
      for (int j = 0; j < 2; j++) if ($urandom_range(0, 1) == 1) set_wr(j, int'($urandom_range(0, 15)), $urandom);
      for (int k = 0; k < 2; k++) if ($urandom_range(0, 2) != 0) set_rsv(k, int'($urandom_range(0, 15)));
      cycle($sformatf("rnd%0d", n));
      if (n == 150) pulse_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
